// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat initiator driven by a valid/ready command port.
// Each accepted command produces one bus cycle and exactly one response.
// A response reports either the acknowledged data or a bus timeout.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [3:0]  cmd_sel_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy_o
);

   localparam int unsigned TW = 8;
   // Last timer value before expiry; the strobe is then up for TIMEOUT cycles.
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state_q;
   logic [TW-1:0] tmr_q;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [3:0]    sel_q;
   logic [31:0]   adr_q;
   logic [31:0]   dat_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_dat_q;
   logic          rsp_err_q;
   logic          rdy_q;
   logic          busy_q;

   // Command FSM: every output is a register updated alongside the state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         rdy_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  state_q <= BUS;
                  tmr_q   <= '0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= cmd_we_i;
                  sel_q   <= cmd_sel_i;
                  adr_q   <= cmd_adr_i;
                  dat_q   <= cmd_dat_i;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            BUS: begin
               // Ack takes priority over a timeout expiring in the same cycle.
               if (wbm_ack_i) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
                  rsp_err_q   <= 1'b0;
               end else if (tmr_q == TMR_LAST) begin
                  state_q     <= RESP;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= '0;
                  rsp_err_q   <= 1'b1;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rdy_q       <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready_o = rdy_q;
   assign busy_o      = busy_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;

endmodule
